uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one peripheral UART transmitter between REQUESTERS byte-stream sources (management core, user cores, debug).
//  Round-robin arbitration at packet granularity: a grant holds until the source's 'last' byte is sent or the stream stalls.
//  Sits between the requester valid/ready streams and the UART TX engine start/busy interface.
// PARAMETERS
//  REQUESTERS      4     number of sources, 2..8
//  TIMEOUT_CYCLES  1024  idle cycles in DATA before a held grant is revoked; 0 disables the timeout
// PORTS
//  wb_clk_i       in   1             system clock
//  wb_rst_i       in   1             synchronous, active-high reset
//  enable         in   1             0: no new grants; a packet in flight still completes
//  req_valid      in   REQUESTERS    source i has a byte on req_data[8i+:8]
//  req_data       in   8*REQUESTERS  byte lanes, lane i = source i
//  req_last       in   REQUESTERS    byte on lane i ends its packet
//  req_ready      out  REQUESTERS    byte on lane i accepted this cycle (combinational, one-hot or zero)
//  uart_tx_data   out  8             byte to the TX engine, registered
//  uart_tx_start  out  1             one-cycle pulse: TX engine loads uart_tx_data
//  uart_tx_busy   in   1             TX engine shifting; rises the cycle after uart_tx_start
//  grant_active   out  1             a source currently holds the transmitter
//  grant_id       out  3             index of the granted or last-granted source
//  timeout        out  1             one-cycle pulse: grant revoked by the idle timeout
// BEHAVIOUR
//  Reset: state IDLE, req_ready=0, uart_tx_start=0, uart_tx_data=0, grant_active=0, timeout=0,
//   grant_id=REQUESTERS-1 (so source 0 has first priority). Reset mid-byte drops the byte with no pulse.
//  FSM IDLE -> GRANT -> [TAG] -> DATA -> SEND -> DATA | IDLE.
//  IDLE: if enable && |req_valid, grant_id <= first i with req_valid[i], scanning from grant_id+1 mod REQUESTERS.
//   Go to GRANT; grant_active=1 from the next cycle.
//  GRANT: one-cycle settle. Go to TAG if the tag feature is compiled in, else to DATA.
//  DATA: req_ready[g] = req_valid[g] && !uart_tx_busy (g = grant_id); all other ready bits are 0.
//   On handshake at cycle T: uart_tx_data <= lane g, last latched, uart_tx_start=1 at T+1, state SEND.
//  SEND: the first cycle ignores busy (engine raises busy at T+2).
//   Then wait for !uart_tx_busy. Latched last=1: go to IDLE, clearing grant_active. Otherwise go to DATA.
//  Turnaround: a new grant is possible at the earliest 2 cycles after the last byte's busy falls. No grant is skipped.
//  Max 1 byte in flight; req_ready is never asserted while busy or in SEND, so uart_tx_start never overlaps busy.
//  Timeout: an idle counter counts DATA cycles with req_valid[g]=0 and clears on each handshake.
//   On reaching TIMEOUT_CYCLES: timeout pulses 1 cycle, state IDLE, grant_active=0.
//   Counter width is $clog2(TIMEOUT_CYCLES+1) and the count saturates.
//  Deasserting enable mid-packet has no effect until the packet ends or times out.
//  A requester withdrawing valid without last is handled only by the timeout.
//  Valid bits of non-granted sources are ignored and never lose their queue position.
//  Round-robin wrap: after grant REQUESTERS-1 the scan starts at 0.
//  Simultaneous valids in IDLE: the lowest index at or after grant_id+1 wins.
// CONFIGURATION
//  UART_ARB_SOURCE_TAG_EN defined: TAG state sends header byte {5'b10100, grant_id} via the same start/SEND handshake
//   before the first data byte; req_ready stays 0 during TAG. The timeout counter is held at 0 in TAG.
//  Undefined: the TAG state does not exist; GRANT goes directly to DATA and no header bytes appear on uart_tx_data.
// TESTING
//  1 single packet: src0 sends 0x41,0x42(last), engine busy 10 cycles/byte ->
//    two start pulses, data 0x41 then 0x42, grant_active falls after busy drops.
//  2 fairness: all 4 valid, each sends a 1-byte packet continuously -> grant order 0,1,2,3,0; no source granted twice in a row.
//  3 packet lock: src1 sends a 3-byte packet while src0 stays valid -> all 3 src1 bytes go first, then src0 is granted.
//  4 timeout: TIMEOUT_CYCLES=16, src2 sends 1 byte without last, then drops valid ->
//    timeout pulses exactly 16 DATA cycles after the handshake; src3 is then granted.
//  5 reset mid-SEND: assert wb_rst_i during busy -> next cycle all outputs at reset values, grant_id=3, no start pulse.
//  6 with UART_ARB_SOURCE_TAG_EN: src2 sends 0x55(last) -> bytes 0xA2 then 0x55; without the macro, only 0x55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX engine between byte-stream sources.
// Define UART_ARB_SOURCE_TAG_EN to prefix each granted packet with a {5'b10100, grant_id} header.
module uart_tx_arbiter #(
  parameter int unsigned REQUESTERS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    enable,
  input  logic [REQUESTERS-1:0]   req_valid,
  input  logic [8*REQUESTERS-1:0] req_data,
  input  logic [REQUESTERS-1:0]   req_last,
  output logic [REQUESTERS-1:0]   req_ready,
  output logic [7:0]              uart_tx_data,
  output logic                    uart_tx_start,
  input  logic                    uart_tx_busy,
  output logic                    grant_active,
  output logic [2:0]              grant_id,
  output logic                    timeout
);

  localparam int unsigned IdW  = $clog2(REQUESTERS);
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntSat = CntW'(TIMEOUT_CYCLES);

`ifdef UART_ARB_SOURCE_TAG_EN
  typedef enum logic [2:0] {StIdle, StGrant, StTag, StData, StSend} state_e;
`else
  typedef enum logic [2:0] {StIdle, StGrant, StData, StSend} state_e;
`endif

  state_e          state_q, state_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic            grant_active_q, grant_active_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            last_q, last_d;
  logic            send_first_q, send_first_d;
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic            timeout_q, timeout_d;

  logic [IdW-1:0]  gsel;
  logic [IdW-1:0]  scan;
  logic [2:0]      pick_id;
  logic            pick_found;
  logic [CntW-1:0] cnt_inc;
  logic [7:0]      lane_data;

  assign gsel      = grant_id_q[IdW-1:0];
  assign lane_data = req_data[{gsel, 3'b000} +: 8];

  // Scan starts just after the last grant, so the previous owner ranks lowest.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = grant_id_q;
    scan       = '0;
    for (int unsigned k = 1; k <= REQUESTERS; k++) begin
      scan = IdW'((32'(grant_id_q) + k) % REQUESTERS);
      if (!pick_found && req_valid[scan]) begin
        pick_found = 1'b1;
        pick_id    = 3'(scan);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    last_d         = last_q;
    send_first_d   = 1'b0;
    idle_cnt_d     = idle_cnt_q;
    timeout_d      = 1'b0;
    req_ready      = '0;
    cnt_inc        = (idle_cnt_q == CntSat) ? idle_cnt_q : idle_cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        idle_cnt_d = '0;
        if (enable && pick_found) begin
          grant_id_d     = pick_id;
          grant_active_d = 1'b1;
          state_d        = StGrant;
        end
      end
      StGrant: begin
`ifdef UART_ARB_SOURCE_TAG_EN
        state_d = StTag;
`else
        state_d = StData;
`endif
      end
`ifdef UART_ARB_SOURCE_TAG_EN
      StTag: begin
        idle_cnt_d = '0;
        if (!uart_tx_busy) begin
          tx_data_d    = {5'b10100, grant_id_q};
          tx_start_d   = 1'b1;
          last_d       = 1'b0;
          send_first_d = 1'b1;
          state_d      = StSend;
        end
      end
`endif
      StData: begin
        if (req_valid[gsel]) begin
          if (!uart_tx_busy) begin
            req_ready[gsel] = 1'b1;
            tx_data_d       = lane_data;
            last_d          = req_last[gsel];
            tx_start_d      = 1'b1;
            send_first_d    = 1'b1;
            idle_cnt_d      = '0;
            state_d         = StSend;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          idle_cnt_d = cnt_inc;
          if (cnt_inc == CntSat) begin
            timeout_d      = 1'b1;
            grant_active_d = 1'b0;
            state_d        = StIdle;
          end
        end
      end
      StSend: begin
        // Busy is not yet valid in the start cycle; the engine raises it one cycle later.
        if (!send_first_q && !uart_tx_busy) begin
          if (last_q) begin
            grant_active_d = 1'b0;
            state_d        = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q        <= StIdle;
      grant_id_q     <= 3'(REQUESTERS - 1);
      grant_active_q <= 1'b0;
      tx_data_q      <= 8'h00;
      tx_start_q     <= 1'b0;
      last_q         <= 1'b0;
      send_first_q   <= 1'b0;
      idle_cnt_q     <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      last_q         <= last_d;
      send_first_q   <= send_first_d;
      idle_cnt_q     <= idle_cnt_d;
      timeout_q      <= timeout_d;
    end
  end

  assign uart_tx_data  = tx_data_q;
  assign uart_tx_start = tx_start_q;
  assign grant_active  = grant_active_q;
  assign grant_id      = grant_id_q;
  assign timeout       = timeout_q;

endmodule
